// File: rtl/bcd_seg_display.sv
// Binary-to-decimal 7-segment display driver: sequential double-dabble converter
// with leading-zero blanking, overflow dashes and a one-deep pending request slot.
//
// state  | meaning
// IDLE   | waiting for load
// SHIFT  | double-dabble add-3/shift, one bit per cycle, WIDTH cycles
// UPDATE | register decoded digits, pulse done, chain pending/new request
module bcd_seg_display #(
    parameter int WIDTH    = 5,
    parameter int DIGITS   = 2,
    parameter int BLANK_LZ = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      value,
    input  logic                  load,
    output logic [7*DIGITS-1:0]   hex,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow
);

    typedef enum logic [1:0] {IDLE, SHIFT, UPDATE} state_t;

    localparam int CW = (WIDTH < 2) ? 1 : $clog2(WIDTH);
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic longint unsigned max_disp(input int d);
        longint unsigned p = 1;
        for (int i = 0; i < d; i++) p = p * 10;
        return p - 1;
    endfunction

    function automatic logic [7*DIGITS-1:0] reset_hex(input int blank);
        logic [7*DIGITS-1:0] r;
        for (int i = 0; i < DIGITS; i++)
            r[7*i+:7] = (i == 0 || blank == 0) ? SEG_ZERO : SEG_BLANK;
        return r;
    endfunction

    localparam longint unsigned     MAX_DISP = max_disp(DIGITS);
    localparam logic [7*DIGITS-1:0] HEX_RST  = reset_hex(BLANK_LZ);

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return SEG_DASH;
        endcase
    endfunction

    function automatic logic is_ovf(input logic [WIDTH-1:0] v);
        return 64'(v) > MAX_DISP;
    endfunction

    state_t                state_q, state_d;
    logic [WIDTH-1:0]      bin_q, bin_d;
    logic [4*DIGITS-1:0]   bcd_q, bcd_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  pend_q, pend_d;
    logic [WIDTH-1:0]      pval_q, pval_d;
    logic                  ovf_cap_q, ovf_cap_d;
    logic [7*DIGITS-1:0]   hex_q, hex_d;
    logic                  done_q, done_d;
    logic                  overflow_q, overflow_d;

    logic [4*DIGITS-1:0]   bcd_adj;
    logic [7*DIGITS-1:0]   hex_new;
    logic                  lead_zero;

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < DIGITS; i++)
            if (bcd_q[4*i+:4] >= 4'd5) bcd_adj[4*i+:4] = bcd_q[4*i+:4] + 4'd3;
    end

    // Walk from the most significant digit so blanking stops at the first non-zero.
    always_comb begin
        hex_new   = '0;
        lead_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (ovf_cap_q)
                hex_new[7*i+:7] = SEG_DASH;
            else if (BLANK_LZ != 0 && i > 0 && lead_zero && bcd_q[4*i+:4] == 4'd0)
                hex_new[7*i+:7] = SEG_BLANK;
            else
                hex_new[7*i+:7] = seg7(bcd_q[4*i+:4]);
            if (bcd_q[4*i+:4] != 4'd0) lead_zero = 1'b0;
        end
    end

    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        pend_d     = pend_q;
        pval_d     = pval_q;
        ovf_cap_d  = ovf_cap_q;
        hex_d      = hex_q;
        done_d     = 1'b0;
        overflow_d = overflow_q;
        case (state_q)
            IDLE: begin
                if (load) begin
                    bin_d     = value;
                    bcd_d     = '0;
                    cnt_d     = '0;
                    ovf_cap_d = is_ovf(value);
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
                cnt_d          = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) state_d = UPDATE;
                if (load) begin
                    pend_d = 1'b1;
                    pval_d = value;
                end
            end
            UPDATE: begin
                hex_d      = hex_new;
                overflow_d = ovf_cap_q;
                done_d     = 1'b1;
                if (pend_q) begin
                    bin_d     = pval_q;
                    bcd_d     = '0;
                    cnt_d     = '0;
                    ovf_cap_d = is_ovf(pval_q);
                    pend_d    = 1'b0;
                    state_d   = SHIFT;
                end else if (load) begin
                    bin_d     = value;
                    bcd_d     = '0;
                    cnt_d     = '0;
                    ovf_cap_d = is_ovf(value);
                    state_d   = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            bin_q      <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            pend_q     <= 1'b0;
            pval_q     <= '0;
            ovf_cap_q  <= 1'b0;
            hex_q      <= HEX_RST;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            pval_q     <= pval_d;
            ovf_cap_q  <= ovf_cap_d;
            hex_q      <= hex_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
        end
    end

    assign hex      = hex_q;
    assign done     = done_q;
    assign overflow = overflow_q;
    assign busy     = (state_q != IDLE) | pend_q;

endmodule

// File: tb/tb_bcd_seg_display.sv
// Scoreboard bench for bcd_seg_display: three parameterisations share one stimulus
// stream; a transaction-level model predicts each displayed value and its done edge.
module tb_bcd_seg_display;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, load;
    logic [4:0]  value;
    logic [13:0] hex_a, hex_b;
    logic [6:0]  hex_c;
    logic        busy_a, busy_b, busy_c;
    logic        done_a, done_b, done_c;
    logic        ovf_a, ovf_b, ovf_c;

    bcd_seg_display #(.WIDTH(5), .DIGITS(2), .BLANK_LZ(1)) dut_a (
        .clk(clk), .reset(reset), .value(value), .load(load),
        .hex(hex_a), .busy(busy_a), .done(done_a), .overflow(ovf_a));
    bcd_seg_display #(.WIDTH(5), .DIGITS(2), .BLANK_LZ(0)) dut_b (
        .clk(clk), .reset(reset), .value(value), .load(load),
        .hex(hex_b), .busy(busy_b), .done(done_b), .overflow(ovf_b));
    bcd_seg_display #(.WIDTH(5), .DIGITS(1), .BLANK_LZ(1)) dut_c (
        .clk(clk), .reset(reset), .value(value), .load(load),
        .hex(hex_c), .busy(busy_c), .done(done_c), .overflow(ovf_c));

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    logic rst_last;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_last <= reset;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            default: return 7'b0010000;
        endcase
    endfunction

    // Display straight from decimal arithmetic: digit i = (v / 10^i) % 10.
    function automatic logic [13:0] ref_hex(input int v, input int digits, input bit blank);
        logic [13:0] r;
        int lim, p;
        r   = '0;
        lim = 1;
        for (int i = 0; i < digits; i++) lim = lim * 10;
        p = 1;
        for (int i = 0; i < digits; i++) begin
            if (v >= lim)                  r[7*i+:7] = 7'b0111111;
            else if (blank && i > 0 && v < p) r[7*i+:7] = 7'b1111111;
            else                           r[7*i+:7] = seg_of((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    typedef struct {
        logic [13:0] ha;
        logic [13:0] hb;
        logic [6:0]  hc;
        logic        oa;
        logic        oc;
        int          e;
    } exp_t;
    exp_t q[$];

    // Model: remaining cycles to the display update, one pending slot.
    int rem  = 0;
    bit pend = 0;
    int pval = 0;
    int cur  = 0;

    task automatic push_expect(input int v, input int e);
        exp_t x;
        logic [13:0] t;
        x.ha = ref_hex(v, 2, 1'b1);
        x.hb = ref_hex(v, 2, 1'b0);
        t    = ref_hex(v, 1, 1'b1);
        x.hc = t[6:0];
        x.oa = (v > 99);
        x.oc = (v > 9);
        x.e  = e;
        q.push_back(x);
    endtask

    task automatic step(input bit ld, input int v, input bit rn);
        int e;
        load  = ld;
        value = v[4:0];
        reset = rn;
        e     = cyc + 1;
        if (!rn) begin
            rem  = 0;
            pend = 0;
        end else if (rem == 0) begin
            if (ld) begin cur = v; rem = 6; end
        end else if (rem == 1) begin
            push_expect(cur, e);
            if (pend) begin cur = pval; pend = 0; rem = 6; end
            else if (ld) begin cur = v; rem = 6; end
            else rem = 0;
        end else begin
            if (ld) begin pend = 1; pval = v; end
            rem--;
        end
        @(posedge clk);
        #1;
        chk("busy_a", 32'(busy_a), 32'((rem > 0) || pend));
        chk("busy_b", 32'(busy_b), 32'((rem > 0) || pend));
        chk("busy_c", 32'(busy_c), 32'((rem > 0) || pend));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 1'b1);
    endtask

    task automatic check_reset_vals();
        chk("rst_hex_a", 32'(hex_a), 32'(14'b1111111_1000000));
        chk("rst_hex_b", 32'(hex_b), 32'(14'b1000000_1000000));
        chk("rst_hex_c", 32'(hex_c), 32'(7'b1000000));
        chk("rst_done",  32'({done_a, done_b, done_c}), 32'(0));
        chk("rst_ovf",   32'({ovf_a, ovf_b, ovf_c}), 32'(0));
    endtask

    logic [13:0] prev_a, prev_b;
    logic [6:0]  prev_c;

    always @(negedge clk) begin
        exp_t x;
        if (done_a || done_b || done_c) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: done=%b%b%b with empty queue (cycle %0d)",
                         done_a, done_b, done_c, cyc);
            end else begin
                x = q.pop_front();
                chk("done_cycle", 32'(cyc), 32'(x.e));
                chk("done_bc", 32'({done_a, done_b, done_c}), 32'(3'b111));
                chk("hex_a", 32'(hex_a), 32'(x.ha));
                chk("hex_b", 32'(hex_b), 32'(x.hb));
                chk("hex_c", 32'(hex_c), 32'(x.hc));
                chk("ovf_a", 32'(ovf_a), 32'(x.oa));
                chk("ovf_b", 32'(ovf_b), 32'(x.oa));
                chk("ovf_c", 32'(ovf_c), 32'(x.oc));
            end
        end else if (rst_last === 1'b1) begin
            chk("hold_hex", 32'({hex_a, hex_b, hex_c}), 32'({prev_a, prev_b, prev_c}));
        end
        prev_a = hex_a;
        prev_b = hex_b;
        prev_c = hex_c;
    end

    initial begin
        reset = 1'b0;
        load  = 1'b0;
        value = '0;
        step(1'b0, 0, 1'b0);
        step(1'b0, 0, 1'b0);
        check_reset_vals();

        step(1'b1, 16, 1'b1); idle(8);
        step(1'b1, 7, 1'b1);  idle(8);
        step(1'b1, 0, 1'b1);  idle(8);
        step(1'b1, 12, 1'b1); idle(8);
        step(1'b1, 9, 1'b1);  idle(8);
        step(1'b1, 31, 1'b1); idle(8);

        // pending overwrite: 25 replaced by 11 before the first conversion ends
        step(1'b1, 3, 1'b1);
        step(1'b0, 0, 1'b1);
        step(1'b1, 25, 1'b1);
        step(1'b1, 11, 1'b1);
        idle(16);

        // load exactly in the update cycle
        step(1'b1, 20, 1'b1);
        idle(5);
        step(1'b1, 5, 1'b1);
        idle(8);

        // reset mid-conversion at the third edge after load
        step(1'b1, 31, 1'b1);
        idle(2);
        step(1'b0, 0, 1'b0);
        check_reset_vals();
        idle(8);
        step(1'b1, 31, 1'b1);
        idle(8);

        for (int i = 0; i < 600; i++) begin
            bit rn, ld;
            int v;
            rn = ($urandom_range(0, 79) != 0);
            ld = ($urandom_range(0, 2) == 0);
            v  = int'($urandom_range(0, 31));
            step(ld, v, rn);
        end
        idle(12);
        chk("queue_drained", 32'(q.size()), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
